arith_result_serializer: RTL and testbench
==========================================

Name: arith_result_serializer

Overview:
- Downstream stage of the combinational 3-bit arithmetic unit.
- Captures one operand pair (A, B) and the unit's five results (sum, difference, product, quotient, remainder) with a valid/ready handshake.
- Emits the five results one beat at a time on a narrow tagged output stream.
- Flags and sanitises divide-by-zero results, because the arithmetic unit leaves its quotient and remainder undefined when B=0.

Parameters:
- OP_W, 3, operand width. Result widths derive from it: sum OP_W+1, diff/quot/rem OP_W, prod 2*OP_W-1; out_data is 2*OP_W-1.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream results and operands are valid.
- in_ready  out  1  block can accept a frame.
- a  in  OP_W  operand A as presented to the arithmetic unit.
- b  in  OP_W  operand B (used for the divide-by-zero check).
- y_sum  in  OP_W+1  A+B.
- y_diff  in  OP_W  A-B, modulo 2^OP_W.
- y_prod  in  2*OP_W-1  A*B, truncated.
- y_quot  in  OP_W  A/B.
- y_rem  in  OP_W  A%B.
- out_valid  out  1  output beat is valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  2*OP_W-1  result, zero-extended.
- out_tag  out  3  0=sum, 1=diff, 2=prod, 3=quot, 4=rem.
- out_last  out  1  final beat of the frame.
- out_err  out  1  beat carries a sanitised divide-by-zero value.
- frame_cnt  out  CNT_W  frames fully emitted, wrapping.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_tag=0, out_last=0, out_err=0, frame_cnt=0, FSM=IDLE, capture registers=0.
- FSM states: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, register all five results and dz=(b==0).
  - Next state SEND, idx=0.
- SEND:
  - in_ready=0 (no same-cycle accept/bypass).
  - out_valid=1, out_tag=idx, out_data=zero-extended captured result[idx].
  - On out_valid && out_ready, idx increments.
  - On the handshake of the last beat: go to IDLE, frame_cnt+1 (wraps 2^CNT_W-1 -> 0).
- Latency: first beat out_valid is asserted the cycle after input acceptance. A full frame with out_ready held high takes 5 cycles in SEND. in_ready returns the cycle after the last handshake.
- Backpressure: while out_valid && !out_ready, out_data, out_tag, out_last and out_err stay stable.
- out_last: asserted only on the final beat (tag 4, or tag 2 under the optional feature).
- Divide-by-zero: when dz=1, beats with tag 3 and 4 carry out_data=0 and out_err=1. All other beats have out_err=0.
- Arithmetic: no recomputation; values pass through exactly as captured. Zero-extension is on the MSB side.
- Reset mid-frame: the frame is discarded, the FSM returns to IDLE, and frame_cnt is not incremented beyond its reset value.
- Upstream changes: changes to the input buses while in_ready=0 have no effect.

Optional Feature:
- Macro: ARITH_SER_DIVZ_SKIP_EN.
- Defined:
  - When dz=1, the frame is 3 beats (tags 0, 1, 2); out_last is on tag 2 and no out_err beats are produced.
  - When dz=0, the frame is 5 beats as normal.
  - frame_cnt increments once per frame in either case.
- Undefined: a frame is always 5 beats, with sanitised quot/rem beats as described above.

Test Plan:
- A=5, B=3 (sum 8, diff 2, prod 15, quot 1, rem 2), out_ready=1 -> beats (tag,data) (0,8)(1,2)(2,15)(3,1)(4,2); out_last on tag 4 only; out_err=0; frame_cnt 0->1; in_ready high the cycle after the last beat.
- A=2, B=5 (diff 5, prod 10, quot 0, rem 2) with out_ready low 3 cycles on tag 1 -> tag 1/data 5 held stable for 3 cycles; frame resumes; in_valid pulses during SEND are ignored.
- A=6, B=0 (quot/rem inputs driven 7) -> tags 3,4 carry data 0 with out_err=1. With ARITH_SER_DIVZ_SKIP_EN: 3 beats, out_last on tag 2 (prod 0).
- A=7, B=7 (sum 14, prod 49 truncated to 17) -> out_data 14 for tag 0 and 17 for tag 2; quot 1, rem 0.
- rst_n asserted low on the tag 2 beat -> out_valid, in_ready and the frame data return to reset values immediately (asynchronously); frame_cnt 0; next frame starts at tag 0.
- 256 back-to-back frames -> frame_cnt wraps 255->0; no beat lost or duplicated.

Source files
------------

// File: rtl/arith_result_serializer.sv
// Captures one operand/result frame from the 3-bit arithmetic unit and replays it as tagged beats.
// Optional build macro ARITH_SER_DIVZ_SKIP_EN: divide-by-zero frames stop after the product beat.
module arith_result_serializer #(
  parameter int OP_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [OP_W:0]     y_sum,
  input  logic [OP_W-1:0]   y_diff,
  input  logic [2*OP_W-2:0] y_prod,
  input  logic [OP_W-1:0]   y_quot,
  input  logic [OP_W-1:0]   y_rem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-2:0] out_data,
  output logic [2:0]        out_tag,
  output logic              out_last,
  output logic              out_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int DW = 2*OP_W-1;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // valid never waits on ready, and a beat's payload holds until it transfers.
  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [OP_W:0]      cap_sum;
  logic [OP_W-1:0]    cap_diff;
  logic [2*OP_W-2:0]  cap_prod;
  logic [OP_W-1:0]    cap_quot;
  logic [OP_W-1:0]    cap_rem;
  logic               cap_dz;
  logic               accept;
  logic               frame_done;
  logic [2:0]         last_idx;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_tag    = '0;
    out_last   = 1'b0;
    out_err    = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    last_idx   = 3'd4;
`ifdef ARITH_SER_DIVZ_SKIP_EN
    if (cap_dz) last_idx = 3'd2;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SEND;
          idx_nxt   = 3'd0;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_tag   = idx;
        out_last  = (idx == last_idx);
        case (idx)
          3'd0: out_data = DW'(cap_sum);
          3'd1: out_data = DW'(cap_diff);
          3'd2: out_data = cap_prod;
          // Quotient/remainder are undefined upstream when B=0, so they are forced to zero.
          3'd3: begin
            out_err  = cap_dz;
            out_data = cap_dz ? '0 : DW'(cap_quot);
          end
          3'd4: begin
            out_err  = cap_dz;
            out_data = cap_dz ? '0 : DW'(cap_rem);
          end
          default: out_data = '0;
        endcase
        if (out_ready) begin
          if (out_last) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
            idx_nxt    = 3'd0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cap_sum   <= '0;
      cap_diff  <= '0;
      cap_prod  <= '0;
      cap_quot  <= '0;
      cap_rem   <= '0;
      cap_dz    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        cap_sum  <= y_sum;
        cap_diff <= y_diff;
        cap_prod <= y_prod;
        cap_quot <= y_quot;
        cap_rem  <= y_rem;
        cap_dz   <= (b == '0);
      end
      if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Upstream contract: sum and difference presented with a frame match its operands.
  sum_diff_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> ((y_sum == ((OP_W+1)'(a) + (OP_W+1)'(b))) && (y_diff == a - b)));

endmodule

// File: tb/tb_arith_result_serializer.sv
// Bench for arith_result_serializer: directed table, hand-written corner sequences,
// randomized frames against a beat-level reference model with a scoreboard queue.
module tb_arith_result_serializer;

  localparam int W = 10; // {tag[2:0], data[4:0], last, err}

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] a, b;
  logic [3:0] y_sum;
  logic [2:0] y_diff;
  logic [4:0] y_prod;
  logic [2:0] y_quot, y_rem;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [2:0] out_tag;
  logic       out_last;
  logic       out_err;
  logic [7:0] frame_cnt;

  arith_result_serializer #(.OP_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .y_sum(y_sum), .y_diff(y_diff), .y_prod(y_prod),
    .y_quot(y_quot), .y_rem(y_rem), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last), .out_err(out_err),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [2:0] a, b;
    logic [3:0] sum;
    logic [2:0] diff;
    logic [4:0] prod;
    logic [2:0] quot, rem;
    logic [4:0] e0, e1, e2, e3, e4;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           exp_frames = 0;
  int           rdy_mode = 0; // 0: ready high, 1: random, 2: driven by the test
  vec_t         tbl[8];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic vec_t model_row();
    vec_t v;
    int ia, ib;
    ia = $urandom_range(0, 7);
    ib = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7);
    v.a    = 3'(ia);
    v.b    = 3'(ib);
    v.sum  = 4'(ia + ib);
    v.diff = 3'((ia - ib + 8) % 8);
    v.prod = 5'((ia * ib) % 32);
    v.e0   = 5'(ia + ib);
    v.e1   = 5'((ia - ib + 8) % 8);
    v.e2   = 5'((ia * ib) % 32);
    if (ib != 0) begin
      v.quot = 3'(ia / ib);
      v.rem  = 3'(ia % ib);
      v.e3   = 5'(ia / ib);
      v.e4   = 5'(ia % ib);
    end else begin
      v.quot = 3'($urandom_range(0, 7));
      v.rem  = 3'($urandom_range(0, 7));
      v.e3   = 5'd0;
      v.e4   = 5'd0;
    end
    return v;
  endfunction

  task automatic push_frame(input vec_t v);
    logic [4:0] e[5];
    logic       dz;
    int         n;
    e  = '{v.e0, v.e1, v.e2, v.e3, v.e4};
    dz = (v.b == 3'd0);
    n  = 5;
`ifdef ARITH_SER_DIVZ_SKIP_EN
    if (dz) n = 3;
`endif
    for (int i = 0; i < n; i++)
      exp_q.push_back({3'(i), e[i], (i == n - 1), (dz && i >= 3)});
    exp_frames++;
  endtask

  // ---------------- drivers ----------------
  task automatic send(input vec_t v);
    int guard = 0;
    in_valid = 1'b1;
    a = v.a; b = v.b; y_sum = v.sum; y_diff = v.diff;
    y_prod = v.prod; y_quot = v.quot; y_rem = v.rem;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 3'($urandom); b = 3'($urandom); y_sum = 4'($urandom); y_diff = 3'($urandom);
    y_prod = 5'($urandom); y_quot = 3'($urandom); y_rem = 3'($urandom);
  endtask

  task automatic apply_row(input vec_t v);
    push_frame(v);
    send(v);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && in_ready) break;
      @(posedge clk); #1;
    end
    check("idle_timeout", (exp_q.size() == 0 && in_ready), 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard / monitor ----------------
  logic         hold = 1'b0;
  logic [W-1:0] held;

  always @(negedge clk) begin
    logic [W-1:0] cur, exp;
    if (rst_n && out_valid) begin
      cur = {out_tag, out_data, out_last, out_err};
      if (hold) check("stable_beat", cur, held);
      if (out_ready) begin
        hold = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", cur, '1);
        end else begin
          exp = exp_q.pop_front();
          check("beat", cur, exp);
        end
      end else begin
        hold = 1'b1;
        held = cur;
      end
    end else begin
      hold = 1'b0;
    end
  end

  // ---------------- test ----------------
  initial begin
    int cycles;
    tbl[0] = '{3'd5, 3'd3, 4'd8,  3'd2, 5'd15, 3'd1, 3'd2, 5'd8,  5'd2, 5'd15, 5'd1, 5'd2};
    tbl[1] = '{3'd2, 3'd5, 4'd7,  3'd5, 5'd10, 3'd0, 3'd2, 5'd7,  5'd5, 5'd10, 5'd0, 5'd2};
    tbl[2] = '{3'd6, 3'd0, 4'd6,  3'd6, 5'd0,  3'd7, 3'd7, 5'd6,  5'd6, 5'd0,  5'd0, 5'd0};
    tbl[3] = '{3'd7, 3'd7, 4'd14, 3'd0, 5'd17, 3'd1, 3'd0, 5'd14, 5'd0, 5'd17, 5'd1, 5'd0};
    tbl[4] = '{3'd0, 3'd0, 4'd0,  3'd0, 5'd0,  3'd5, 3'd3, 5'd0,  5'd0, 5'd0,  5'd0, 5'd0};
    tbl[5] = '{3'd7, 3'd1, 4'd8,  3'd6, 5'd7,  3'd7, 3'd0, 5'd8,  5'd6, 5'd7,  5'd7, 5'd0};
    tbl[6] = '{3'd3, 3'd6, 4'd9,  3'd5, 5'd18, 3'd0, 3'd3, 5'd9,  5'd5, 5'd18, 5'd0, 5'd3};
    tbl[7] = '{3'd4, 3'd7, 4'd11, 3'd5, 5'd28, 3'd0, 3'd4, 5'd11, 5'd5, 5'd28, 5'd0, 5'd4};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; y_sum = '0; y_diff = '0; y_prod = '0; y_quot = '0; y_rem = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_err", out_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: first beat one cycle after accept, five SEND cycles with ready held high.
    apply_row(tbl[0]);
    check("first_beat_valid", out_valid, 1);
    check("first_beat_tag", out_tag, 0);
    check("first_beat_in_ready", in_ready, 0);
    cycles = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      cycles = k;
      if (in_ready) break;
    end
    check("send_cycles", cycles, 5);
    check("frame_cnt_first", frame_cnt, 1);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      apply_row(tbl[i]);
      wait_idle();
      check("table_frame_cnt", frame_cnt, 32'(exp_frames % 256));
    end

    // Backpressure on tag 1 with stray in_valid pulses.
    rdy_mode = 2;
    out_ready = 1'b1;
    apply_row(tbl[1]);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = 3'd1; b = 3'd1; y_sum = 4'd2; y_diff = 3'd0; y_prod = 5'd1; y_quot = 3'd1; y_rem = 3'd0;
      @(posedge clk); #1;
      check("bp_tag", out_tag, 1);
      check("bp_data", out_data, 5);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rdy_mode = 0;
    wait_idle();
    check("bp_frame_cnt", frame_cnt, 32'(exp_frames % 256));

    // Randomized frames with random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) apply_row(model_row());
    wait_idle();
    rdy_mode = 0;
    check("rand_frame_cnt", frame_cnt, 32'(exp_frames % 256));

    // Asynchronous reset on the tag 2 beat.
    apply_row(tbl[0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_tag", out_tag, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_tag", out_tag, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    exp_frames = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_row(tbl[0]);
    check("post_rst_tag", out_tag, 0);
    wait_idle();
    check("post_rst_frame_cnt", frame_cnt, 1);

    // 256 back-to-back frames: counter wraps back to its starting value.
    for (int i = 0; i < 256; i++) apply_row(model_row());
    wait_idle();
    check("wrap_frame_cnt", frame_cnt, 32'(exp_frames % 256));
    check("wrap_frame_cnt_base", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
